// File: rtl/ysyx_22050550_wbu.sv
// ysyx_22050550_wbu: single-entry write-back stage with commit, forwarding, halt and instret.
module ysyx_22050550_wbu #(
  parameter int XLEN = 64,
  parameter int INSTRET_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_LSWB_valid,
  input  logic [XLEN-1:0]      io_LSWB_pc,
  input  logic [31:0]          io_LSWB_inst,
  input  logic [4:0]           io_LSWB_wdaddr,
  input  logic                 io_LSWB_wen,
  input  logic                 io_LSWB_readflag,
  input  logic                 io_LSWB_csrflag,
  input  logic                 io_LSWB_jalrflag,
  input  logic [XLEN-1:0]      io_LSWB_alures,
  input  logic [XLEN-1:0]      io_LSWB_lsures,
  input  logic [XLEN-1:0]      io_LSWB_NextPc,
  input  logic                 io_LSWB_ebreak,
  input  logic                 io_LSWB_abort,
  input  logic                 io_LSWB_SkipRef,
  input  logic                 io_LSWB_flush,
  input  logic [XLEN-1:0]      io_CSR_rdata,
  input  logic                 io_WB_stall,
  output logic                 io_ReadyWB_ready,
  output logic                 io_WB_rf_wen,
  output logic [4:0]           io_WB_rf_waddr,
  output logic [XLEN-1:0]      io_WB_rf_wdata,
  output logic                 io_WB_fwd_valid,
  output logic                 io_WB_commit,
  output logic [XLEN-1:0]      io_WB_commit_pc,
  output logic [31:0]          io_WB_commit_inst,
  output logic [XLEN-1:0]      io_WB_commit_nextpc,
  output logic                 io_WB_skipref,
  output logic                 io_WB_halt,
  output logic [XLEN-1:0]      io_WB_halt_pc,
  output logic [INSTRET_W-1:0] io_WB_instret
);
  typedef enum logic [1:0] {IDLE, FULL, HALT} state_t;
  state_t st, st_n;
  logic [XLEN-1:0] pc_q, nextpc_q, wdata_q, halt_pc_q;
  logic [31:0] inst_q;
  logic [4:0] waddr_q;
  logic wen_q, eb_q, ab_q, skip_q, fl_q, halt_q;
  logic [INSTRET_W-1:0] instret_q;
  logic retire, commit, stop, accept, wr_ok;
  assign retire = st == FULL && !io_WB_stall && !reset;
  assign commit = retire && !fl_q;
  assign stop = commit && (eb_q || ab_q);
  assign io_ReadyWB_ready = !reset && (st == IDLE || retire);
  assign accept = io_LSWB_valid && io_ReadyWB_ready;
  assign wr_ok = wen_q && |waddr_q && !ab_q && !fl_q;
  always_comb st_n = stop ? HALT : accept ? FULL : retire ? IDLE : st;
  always_ff @(posedge clock) begin
    if (reset) begin
      st <= IDLE;
      pc_q <= '0;
      nextpc_q <= '0;
      wdata_q <= '0;
      inst_q <= '0;
      waddr_q <= '0;
      {wen_q, eb_q, ab_q, skip_q, fl_q} <= '0;
      halt_q <= 1'b0;
      halt_pc_q <= '0;
      instret_q <= '0;
    end else begin
      st <= st_n;
      if (accept) begin
        pc_q <= io_LSWB_pc;
        nextpc_q <= io_LSWB_NextPc;
        inst_q <= io_LSWB_inst;
        waddr_q <= io_LSWB_wdaddr;
        {wen_q, eb_q, ab_q, skip_q, fl_q} <= {io_LSWB_wen, io_LSWB_ebreak, io_LSWB_abort,
                                              io_LSWB_SkipRef, io_LSWB_flush};
        wdata_q <= io_LSWB_jalrflag ? io_LSWB_pc + XLEN'(4) :
                   io_LSWB_csrflag  ? io_CSR_rdata :
                   io_LSWB_readflag ? io_LSWB_lsures : io_LSWB_alures;
      end
      if (commit) instret_q <= instret_q + INSTRET_W'(1);
      if (stop) begin
        halt_q <= 1'b1;
        halt_pc_q <= pc_q;
      end
    end
  end
  assign io_WB_rf_wen = retire && wr_ok;
  assign io_WB_rf_waddr = reset ? '0 : waddr_q;
  assign io_WB_rf_wdata = reset ? '0 : wdata_q;
  assign io_WB_fwd_valid = !reset && st == FULL && wr_ok;
  assign io_WB_commit = commit;
  assign io_WB_commit_pc = commit ? pc_q : '0;
  assign io_WB_commit_inst = commit ? inst_q : '0;
  assign io_WB_commit_nextpc = commit ? nextpc_q : '0;
  assign io_WB_skipref = commit && skip_q;
  // Halt is visible in the commit cycle itself, then held by the sticky register.
  assign io_WB_halt = !reset && (halt_q || stop);
  assign io_WB_halt_pc = reset ? '0 : stop ? pc_q : halt_pc_q;
  assign io_WB_instret = reset ? '0 : instret_q + INSTRET_W'(commit);
endmodule
